// File: rtl/caixa_pkg.sv
// Shared types for the water-tank sensor front end:
// fault FSM encoding and error-code constants.
package caixa_pkg;

    typedef enum logic [1:0] {
        OK       = 2'b00,
        SUSPEITO = 2'b01,
        FALHA    = 2'b10
    } caixa_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_INCONS  = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

endpackage

// File: rtl/sensor_caixa_if.sv
// Float-switch, valve feedback and fault signals of the
// sensor front end, grouped for the level chain.
interface sensor_caixa_if;
    logic       lower_raw;
    logic       upper_raw;
    logic       valve_e;
    logic       clear_erro;
    logic       upper;
    logic       lower;
    logic       erro;
    logic [1:0] err_code;

    modport master (
        output lower_raw,
        output upper_raw,
        output valve_e,
        output clear_erro,
        input  upper,
        input  lower,
        input  erro,
        input  err_code
    );

    modport slave (
        input  lower_raw,
        input  upper_raw,
        input  valve_e,
        input  clear_erro,
        output upper,
        output lower,
        output erro,
        output err_code
    );
endinterface

// File: rtl/sensor_filtro.sv
// Two-flop synchroniser followed by a debounce filter
// for one raw float switch.
module sensor_filtro #(
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            cnt  <= '0;
            filt <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // output only follows after a full window of agreement
            if (s2 != filt) begin
                if (cnt == CMAX) begin
                    filt <= s2;
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

// File: rtl/sensor_caixa.sv
// Sensor conditioning for the tank level chain: filtered
// switches plus latched inconsistency / fill-timeout faults.
module sensor_caixa
    import caixa_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int ERR_CYCLES      = 4,
    parameter int FILL_TIMEOUT    = 1024
) (
    input logic           clock,
    input logic           reset,
    sensor_caixa_if.slave bus
);
    localparam int PW = $clog2(ERR_CYCLES);
    localparam int TW = $clog2(FILL_TIMEOUT);
    localparam logic [PW-1:0] PMAX = PW'(ERR_CYCLES - 1);
    localparam logic [TW-1:0] TMAX = TW'(FILL_TIMEOUT - 1);

    logic          upper_f;
    logic          lower_f;
    caixa_state_t  state;
    logic [PW-1:0] pcnt;
    logic [TW-1:0] tcnt;
    logic          erro_q;
    logic [1:0]    code_q;
    logic          inc;
    logic          filling;
    logic          tmo;

    sensor_filtro #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lower (
        .clock (clock),
        .reset (reset),
        .raw   (bus.lower_raw),
        .filt  (lower_f)
    );

    sensor_filtro #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_upper (
        .clock (clock),
        .reset (reset),
        .raw   (bus.upper_raw),
        .filt  (upper_f)
    );

    assign inc     = upper_f & ~lower_f;
    assign filling = bus.valve_e & ~lower_f;
    assign tmo     = filling & (tcnt == TMAX);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state  <= OK;
            pcnt   <= '0;
            tcnt   <= '0;
            erro_q <= 1'b0;
            code_q <= ERR_NONE;
        end else begin
            // fill timer saturates so a missed fault cannot wrap away
            if (state == FALHA) begin
                tcnt <= '0;
            end else if (filling) begin
                if (tcnt != TMAX) begin
                    tcnt <= tcnt + TW'(1);
                end
            end else begin
                tcnt <= '0;
            end

            unique case (state)
                OK: begin
                    if (inc) begin
                        state <= SUSPEITO;
                        pcnt  <= PW'(1);
                    end else if (tmo) begin
                        state  <= FALHA;
                        erro_q <= 1'b1;
                        code_q <= ERR_TIMEOUT;
                    end
                end
                SUSPEITO: begin
                    if (!inc) begin
                        state <= OK;
                        pcnt  <= '0;
                    end else if (pcnt == PMAX) begin
                        state  <= FALHA;
                        erro_q <= 1'b1;
                        code_q <= ERR_INCONS;
                    end else begin
                        pcnt <= pcnt + PW'(1);
                        if (tmo) begin
                            state  <= FALHA;
                            erro_q <= 1'b1;
                            code_q <= ERR_TIMEOUT;
                        end
                    end
                end
                FALHA: begin
                    if (bus.clear_erro && !inc) begin
                        state  <= OK;
                        pcnt   <= '0;
                        erro_q <= 1'b0;
                        code_q <= ERR_NONE;
                    end
                end
                default: begin
                    state  <= OK;
                    pcnt   <= '0;
                    erro_q <= 1'b0;
                    code_q <= ERR_NONE;
                end
            endcase
        end
    end

    assign bus.upper    = upper_f;
    assign bus.lower    = lower_f;
    assign bus.erro     = erro_q;
    assign bus.err_code = code_q;
endmodule

// File: tb/tb_sensor_caixa.sv
// Bench for sensor_caixa: vector table for the filters plus
// hand sequences for faults, clear and async reset.
module tb_sensor_caixa;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    sensor_caixa_if bus ();

    sensor_caixa #(
        .DEBOUNCE_CYCLES (4),
        .ERR_CYCLES      (3),
        .FILL_TIMEOUT    (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial forever #5 clock = ~clock;

    typedef struct {
        string      nm;
        int         due;
        logic       l;
        logic       u;
        logic       e;
        logic [1:0] c;
    } exp_t;

    typedef struct {
        logic       lr;
        logic       ur;
        logic       ve;
        logic       clr;
        int         hold;
        logic       el;
        logic       eu;
        logic       ee;
        logic [1:0] ec;
    } vec_t;

    exp_t q[$];
    vec_t vt[11];

    task automatic cmp(string nm, logic l, logic u, logic e, logic [1:0] c);
        total++;
        if (bus.lower !== l || bus.upper !== u ||
            bus.erro !== e || bus.err_code !== c) begin
            bad++;
            $display("FAIL %s: got lower=%b upper=%b erro=%b code=%b, want lower=%b upper=%b erro=%b code=%b",
                     nm, bus.lower, bus.upper, bus.erro, bus.err_code, l, u, e, c);
        end
    endtask

    task automatic push(string nm, int k, logic l, logic u, logic e, logic [1:0] c);
        exp_t x;
        x.nm  = nm;
        x.due = cyc + k;
        x.l   = l;
        x.u   = u;
        x.e   = e;
        x.c   = c;
        q.push_back(x);
    endtask

    task automatic drain();
        exp_t x;
        while (q.size() != 0 && q[0].due <= cyc) begin
            x = q.pop_front();
            if (x.due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s: sampled at cycle %0d, required cycle %0d", x.nm, cyc, x.due);
            end else begin
                cmp(x.nm, x.l, x.u, x.e, x.c);
            end
        end
    endtask

    task automatic step(int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            cyc++;
            drain();
        end
    endtask

    task automatic drive(logic lr, logic ur, logic ve, logic clr);
        bus.lower_raw  = lr;
        bus.upper_raw  = ur;
        bus.valve_e    = ve;
        bus.clear_erro = clr;
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 2, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b0, 2'b00};
        vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4, 1'b1, 1'b0, 1'b0, 2'b00};
        vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b0, 2'b00};
        vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0, 2'b00};

        reset = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step(3);
        push("reset_hold", 1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1);

        reset = 1'b1;
        push("release_e5", 5, 1'b0, 1'b0, 1'b0, 2'b00);
        push("release_e6", 6, 1'b1, 1'b1, 1'b0, 2'b00);
        step(6);

        for (int i = 0; i < 11; i++) begin
            drive(vt[i].lr, vt[i].ur, vt[i].ve, vt[i].clr);
            push($sformatf("vec%0d", i), vt[i].hold,
                 vt[i].el, vt[i].eu, vt[i].ee, vt[i].ec);
            step(vt[i].hold);
        end

        // held inconsistency latches code 01
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        push("incons_e8", 8, 1'b0, 1'b1, 1'b0, 2'b00);
        push("incons_e9", 9, 1'b0, 1'b1, 1'b1, 2'b01);
        step(10);

        drive(1'b0, 1'b1, 1'b0, 1'b1);
        push("clr_blocked", 1, 1'b0, 1'b1, 1'b1, 2'b01);
        step(1);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        push("clr_blocked_hold", 3, 1'b0, 1'b1, 1'b1, 2'b01);
        step(3);

        drive(1'b1, 1'b0, 1'b0, 1'b0);
        push("filt_in_falha", 6, 1'b1, 1'b0, 1'b1, 2'b01);
        step(6);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        push("clr_ok", 1, 1'b1, 1'b0, 1'b0, 2'b00);
        step(1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        push("clr_ok_hold", 2, 1'b1, 1'b0, 1'b0, 2'b00);
        step(2);

        // two-cycle inconsistency must not latch
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        push("both_low", 8, 1'b0, 1'b0, 1'b0, 2'b00);
        step(8);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        push("short_e6", 6, 1'b0, 1'b1, 1'b0, 2'b00);
        push("short_e8", 8, 1'b1, 1'b1, 1'b0, 2'b00);
        push("short_e9", 9, 1'b1, 1'b1, 1'b0, 2'b00);
        push("short_e12", 12, 1'b1, 1'b1, 1'b0, 2'b00);
        step(2);
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        step(10);

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        push("pre_tmo", 8, 1'b0, 1'b0, 1'b0, 2'b00);
        step(8);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        push("tmo_e15", 15, 1'b0, 1'b0, 1'b0, 2'b00);
        push("tmo_e16", 16, 1'b0, 1'b0, 1'b1, 2'b10);
        step(17);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        push("tmo_clr", 1, 1'b0, 1'b0, 1'b0, 2'b00);
        step(1);

        // lower arrives at count 10, timer must restart
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        push("fill_e10", 10, 1'b1, 1'b0, 1'b0, 2'b00);
        push("fill_e16", 16, 1'b1, 1'b0, 1'b0, 2'b00);
        push("fill_e24", 24, 1'b1, 1'b0, 1'b0, 2'b00);
        step(4);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        step(20);

        drive(1'b0, 1'b1, 1'b0, 1'b0);
        push("ar_falha", 9, 1'b0, 1'b1, 1'b1, 2'b01);
        step(10);
        #3;
        reset = 1'b0;
        #1;
        cmp("async_reset", 1'b0, 1'b0, 1'b0, 2'b00);
        step(2);
        reset = 1'b1;
        step(2);

        while (q.size() != 0) begin
            exp_t x;
            x = q.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never sampled, due cycle %0d", x.nm, x.due);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
